// File: rtl/exp2_range_reduce.sv
// exp2_range_reduce: splits binary16 x into rounded integer n and fraction x-n for the 2^x path
//   clk, rstn (async active-low)          : clock and reset
//   in_valid, a                           : input sample x (binary16)
//   out_valid, fpart, n, cls              : 3-cycle result; cls 0 NORMAL, 1 OVF, 2 UNF, 3 NAN
//   aligned_valid, n_aligned, cls_aligned : out_valid/n/cls delayed by PADE_LATENCY
module exp2_range_reduce #(
  parameter int BITS = 16,
  parameter PRECISION = "HALF",
  parameter int PADE_LATENCY = 20
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            in_valid,
  input  logic [BITS-1:0] a,
  output logic            out_valid,
  output logic [BITS-1:0] fpart,
  output logic [6:0]      n,
  output logic [1:0]      cls,
  output logic            aligned_valid,
  output logic [6:0]      n_aligned,
  output logic [1:0]      cls_aligned
);
  generate
    if (BITS != 16 || PRECISION != "HALF" || PADE_LATENCY < 1 || PADE_LATENCY > 63) begin : g_bad
      $error("exp2_range_reduce: unsupported parameters");
    end
  endgenerate
  logic        s_in;
  logic [4:0]  e_in;
  logic [9:0]  m_in;
  logic        v1_d, v1_q, v2_q, v3_q;
  logic [1:0]  cls1_d, cls1_q, cls2_q, cls3_q;
  logic        pass1_d, pass1_q, pass2_q;
  logic        s1_q;
  logic [15:0] w1_d, w1_q, w2_d, w2_q, fp3_d, fp3_q;
  logic [5:0]  nm;
  logic [11:0] r, rs, mag;
  logic [6:0]  n2_d, n2_q, n3_q;
  logic [3:0]  lead;
  logic [PADE_LATENCY-1:0][9:0] sb_q;
  assign s_in = a[15];
  assign e_in = a[14:10];
  assign m_in = a[9:0];
  // Bubbles and specials both collapse to a pass-through of zero, so they
  // leave the pipe as fpart=0, n=0 without any extra muxing downstream.
  always_comb begin
    v1_d    = in_valid;
    cls1_d  = !in_valid ? 2'd0 :
              (e_in == 5'd31 && m_in != 10'd0) ? 2'd3 :
              (!s_in && e_in >= 5'd19) ? 2'd1 :
              (s_in && e_in >= 5'd20) ? 2'd2 : 2'd0;
    pass1_d = !in_valid || cls1_d != 2'd0 || e_in < 5'd14;
    w1_d    = (!in_valid || cls1_d != 2'd0) ? 16'd0 :
              (e_in < 5'd14) ? a : ({5'd0, 1'b1, m_in} << (e_in - 5'd14));
  end
  // Round half away from zero on the magnitude: the remainder is simply the
  // low 11 bits of F read as a signed value, and bit 10 decides the carry.
  always_comb begin
    nm   = {1'b0, w1_q[15:11]} + {5'd0, w1_q[10]};
    r    = {w1_q[10], w1_q[10:0]};
    rs   = s1_q ? -r : r;
    n2_d = pass1_q ? 7'd0 : s1_q ? -{1'b0, nm} : {1'b0, nm};
    w2_d = pass1_q ? w1_q : {{4{rs[11]}}, rs};
  end
  always_comb begin
    mag  = w2_q[11] ? -w2_q[11:0] : w2_q[11:0];
    lead = 4'd0;
    for (int i = 0; i < 12; i++)
      if (mag[i]) lead = 4'(i);
    fp3_d = pass2_q ? w2_q :
            (mag == 12'd0) ? 16'd0 :
            {w2_q[11], 5'({1'b0, lead} + 5'd4), 10'(mag << (4'd10 - lead))};
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      v1_q    <= 1'b0;
      cls1_q  <= 2'd0;
      pass1_q <= 1'b0;
      s1_q    <= 1'b0;
      w1_q    <= 16'd0;
      v2_q    <= 1'b0;
      cls2_q  <= 2'd0;
      pass2_q <= 1'b0;
      n2_q    <= 7'd0;
      w2_q    <= 16'd0;
      v3_q    <= 1'b0;
      cls3_q  <= 2'd0;
      n3_q    <= 7'd0;
      fp3_q   <= 16'd0;
      sb_q    <= '0;
    end else begin
      v1_q    <= v1_d;
      cls1_q  <= cls1_d;
      pass1_q <= pass1_d;
      s1_q    <= s_in;
      w1_q    <= w1_d;
      v2_q    <= v1_q;
      cls2_q  <= cls1_q;
      pass2_q <= pass1_q;
      n2_q    <= n2_d;
      w2_q    <= w2_d;
      v3_q    <= v2_q;
      cls3_q  <= cls2_q;
      n3_q    <= n2_q;
      fp3_q   <= fp3_d;
      sb_q[0] <= {v3_q, n3_q, cls3_q};
      for (int i = 1; i < PADE_LATENCY; i++)
        sb_q[i] <= sb_q[i-1];
    end
  end
  assign out_valid = v3_q;
  assign fpart     = fp3_q;
  assign n         = n3_q;
  assign cls       = cls3_q;
  assign {aligned_valid, n_aligned, cls_aligned} = sb_q[PADE_LATENCY-1];
endmodule

// File: doc/exp2_range_reduce.md
Name: exp2_range_reduce

Overview:
- Front-end stage of the half-precision 2^x path.
- Splits the input x into a rounded integer n and a fraction fpart = x - n, with fpart in [-0.5, +0.5]. fpart feeds the Pade 2^fraction approximator.
- Classifies special inputs.
- Carries n and class through a sideband delay line matched to the approximator latency, so the downstream exponent-scaling stage receives them aligned with 2^fpart.

Parameters:
- BITS, 16: word width. Only 16 is supported.
- PRECISION, "HALF": float format. Only "HALF" is supported (IEEE binary16, bias 15).
- PADE_LATENCY, 20: approximator latency in cycles, range 1..63. Sets the sideband delay length.

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- in_valid  in  1  a is valid this cycle
- a  in  BITS  x, binary16
- out_valid  out  1  fpart/n/cls valid
- fpart  out  BITS  x - n, binary16, in [-0.5, 0.5]
- n  out  7  signed rounded integer part
- cls  out  2  0 NORMAL, 1 OVF, 2 UNF, 3 NAN
- aligned_valid  out  1  out_valid delayed by PADE_LATENCY
- n_aligned  out  7  n delayed by PADE_LATENCY
- cls_aligned  out  2  cls delayed by PADE_LATENCY

Behaviour:
- Interface: one clock (clk); asynchronous active-low reset (rstn).
- Reset: all pipeline and sideband registers clear asynchronously. All outputs are 0 after reset.
- Flow control: none (no backpressure). Fully pipelined, one input per cycle, latency 3 from a to fpart/n/cls.
- Bubbles: a cycle with in_valid=0 propagates as a bubble, with out_valid=0, fpart=0x0000, n=0, cls=0.
- Decode a as s, e[4:0], m[9:0].
- Stage 1 (classify/shift):
  - e=31, m≠0 → NAN.
  - e=31, m=0: s=0 → OVF; s=1 → UNF.
  - s=0 and e≥19 (x≥16) → OVF.
  - s=1 and e≥20 (|x|≥32) → UNF.
  - e<14 (|x|<0.5, including subnormals and zeros) → pass-through: fpart=a, n=0.
  - Otherwise (NORMAL), form unsigned fixed F = (1024+m) << (e-14), units 2^-11, 16 bits.
- Stage 2 (round):
  - nm = (F+1024) >> 11, i.e. round to nearest, ties away from zero.
  - r = F - nm*2048, signed 12 bits, in [-1024, 1023].
  - If s=1: n = -nm, r = -r; otherwise n = nm.
- Stage 3 (normalize): convert r·2^-11 to binary16 using leading-one detect. The conversion is exact.
  - r=0 → +0 (0x0000).
- Special classes: OVF/UNF/NAN output fpart=0x0000 and n=0, so the approximator computes a harmless 1.0. cls carries the outcome.
- Ranges: n spans [-32, +16]. Examples: x=15.75 → n=16, fpart=-0.25; x in [-32,-16) → n down to -32.
- Sideband: n, cls and out_valid pass through a PADE_LATENCY-deep shift register that advances every cycle.
  - aligned_* are reset-cleared. Entries are not held during bubbles.
- Reset mid-operation: all in-flight results are discarded. out_valid and aligned_valid stay 0 until new valid inputs traverse the pipe.

Test Plan:
- Basic values, each with cls=0:
  - a=0x3C00 (1.0) → fpart 0x0000, n=1.
  - a=0x4180 (2.75) → fpart 0xB400 (-0.25), n=3.
  - a=0x4BE0 (15.75) → fpart 0xB400, n=16.
- Ties and pass-through:
  - a=0xB800 (-0.5) → fpart 0x3800, n=-1.
  - a=0x3400 → fpart 0x3400, n=0.
  - a=0x0001 (subnormal) → fpart 0x0001, n=0.
- Specials, each with fpart 0x0000 and n=0:
  - a=0x4C00 (16) → cls=1.
  - a=0x7C00 → cls=1.
  - a=0xFC00 → cls=2.
  - a=0xD000 (-32) → cls=2.
  - a=0x7E00 → cls=3.
- Latency and bubbles: stream 1.0, bubble, 2.75 on consecutive cycles → out_valid pattern 1,0,1 starting at cycle 3. The bubble slot shows 0x0000/0/0.
- Alignment: PADE_LATENCY=5, same stream → aligned_valid 1,0,1 starting at cycle 8, with n_aligned = 1, 0, 3.
- Reset: assert rstn=0 with 3 valid items in flight → all outputs 0 immediately. After release, no out_valid appears until a new input is applied 3 cycles earlier.
